// File: rtl/ptl_tx_scheduler.sv
// Round-robin scheduler sharing one PTL transmitter among N_REQ pulse sources,
// enforcing a minimum spacing of GAP cycles between transmitter input pulses.
module ptl_tx_scheduler #(
  parameter int N_REQ = 4,
  parameter int GAP   = 4,
  parameter int CNT_W = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [N_REQ-1:0]           req,
  output logic                       tx_pulse,
  output logic                       tx_level,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy,
  output logic                       pending_any,
  output logic [N_REQ-1:0]           overflow
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {IDLE, FIRE, HOLDOFF} state_t;

  state_t            state_reg, state_next;
  logic [ID_W-1:0]   grant_reg, grant_next;
  logic [GAP_W-1:0]  gap_reg, gap_next;
  logic [ID_W-1:0]   ptr_reg;
  logic              tx_level_reg;
  logic [N_REQ-1:0]  nz;
  logic [N_REQ-1:0]  elig;
  logic [ID_W-1:0]   base;
  logic [ID_W-1:0]   win_id;
  logic              win_valid;

  // Per-requester saturating backlog counters and sticky drop flags.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
    logic [CNT_W-1:0] cnt_reg;
    logic             ovf_reg;
    logic             dec;

    assign dec = (state_reg == FIRE) && (grant_reg == ID_W'(gi));

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_reg <= '0;
        ovf_reg <= 1'b0;
      end else if (req[gi] && !dec) begin
        if (cnt_reg == CNT_MAX) ovf_reg <= 1'b1;
        else                    cnt_reg <= cnt_reg + CNT_W'(1);
      end else if (!req[gi] && dec) begin
        cnt_reg <= cnt_reg - CNT_W'(1);
      end
    end

    assign nz[gi]       = (cnt_reg != '0);
    // The unit being sent in FIRE must not be granted a second time.
    assign elig[gi]     = nz[gi] && !(dec && (cnt_reg == CNT_W'(1)));
    assign overflow[gi] = ovf_reg;
  end

  // In FIRE the pointer has not yet moved, so search from the current winner.
  always_comb begin
    base      = (state_reg == FIRE) ? grant_reg : ptr_reg;
    win_valid = 1'b0;
    win_id    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      int idx;
      idx = (int'(base) + k) % N_REQ;
      if (!win_valid && elig[idx]) begin
        win_valid = 1'b1;
        win_id    = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      grant_reg    <= '0;
      gap_reg      <= '0;
      ptr_reg      <= ID_W'(N_REQ - 1);
      tx_level_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      gap_reg   <= gap_next;
      if (state_reg == FIRE) begin
        ptr_reg      <= grant_reg;
        tx_level_reg <= ~tx_level_reg;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    gap_next   = gap_reg;
    case (state_reg)
      IDLE: begin
        if (en && win_valid) begin
          state_next = FIRE;
          grant_next = win_id;
        end
      end
      FIRE: begin
        if (GAP == 1) begin
          if (en && win_valid) begin
            state_next = FIRE;
            grant_next = win_id;
          end else begin
            state_next = IDLE;
          end
        end else begin
          state_next = HOLDOFF;
          gap_next   = GAP_W'(GAP - 1);
        end
      end
      HOLDOFF: begin
        gap_next = gap_reg - GAP_W'(1);
        if (gap_reg == GAP_W'(1)) begin
          if (en && win_valid) begin
            state_next = FIRE;
            grant_next = win_id;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    tx_pulse = (state_reg == FIRE);
    busy     = (state_reg != IDLE);
    grant_id = (state_reg == FIRE) ? grant_reg : '0;
  end

  assign tx_level    = tx_level_reg;
  assign pending_any = |nz;

endmodule
